// File: rtl/sfx_pkg.sv
// Shared types, note tables and effect scripts for the sound-effect sequencer.
package sfx_pkg;

    localparam int unsigned STEPS_PER_FX = 4;
    localparam int unsigned STEP_W       = 3;
    localparam int unsigned HP_W         = 16;

    typedef enum logic [2:0] {
        FX_FIRE   = 3'd0,
        FX_ALIEN  = 3'd1,
        FX_DIMOND = 3'd2,
        FX_GOLD   = 3'd3,
        FX_WIN    = 3'd4,
        FX_DIED   = 3'd5,
        FX_NONE   = 3'd7
    } fx_e;

    typedef struct packed {
        logic [3:0] note_idx;
        logic [3:0] frames;
    } note_t;

    // Half period in 25 MHz clocks; index 0 is a rest.
    function automatic logic [HP_W-1:0] half_period_of(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'd0;
            4'd1:    return 16'd47710;
            4'd2:    return 16'd42566;
            4'd3:    return 16'd37921;
            4'd4:    return 16'd31888;
            4'd5:    return 16'd23900;
            4'd6:    return 16'd21283;
            4'd7:    return 16'd18961;
            4'd8:    return 16'd11945;
            4'd9:    return 16'd9480;
            4'd10:   return 16'd7972;
            4'd11:   return 16'd7102;
            4'd12:   return 16'd5972;
            4'd13:   return 16'd5321;
            4'd14:   return 16'd4740;
            default: return 16'd3986;
        endcase
    endfunction

    // Script rows pack step 0 in the low byte; out-of-range steps read as end-of-script.
    function automatic note_t script_entry(input logic [2:0] fx, input logic [STEP_W-1:0] step);
        logic [31:0] row;
        case (fx_e'(fx))
            FX_FIRE:   row = 32'h0000_00A1;
            FX_ALIEN:  row = 32'h0000_5282;
            FX_DIMOND: row = 32'h0000_0084;
            FX_GOLD:   row = 32'h00A6_8353;
            FX_WIN:    row = 32'hACA4_8454;
            FX_DIED:   row = 32'h1F04_1858;
            default:   row = 32'h0000_0000;
        endcase
        if (step >= STEP_W'(STEPS_PER_FX)) return '0;
        case (step[1:0])
            2'd0:    return note_t'(row[7:0]);
            2'd1:    return note_t'(row[15:8]);
            2'd2:    return note_t'(row[23:16]);
            default: return note_t'(row[31:24]);
        endcase
    endfunction

endpackage

// File: rtl/sfx_tone_gen.sv
// Square-wave generator: toggles every half_period clocks, silent while rest or on load.
module sfx_tone_gen
    import sfx_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [HP_W-1:0] half_period,
    input  logic            rest,
    output logic            tone
);

    logic [HP_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (load) begin
            cnt  <= half_period - 16'd1;
            tone <= 1'b0;
        end else if (rest) begin
            tone <= 1'b0;
        end else if (cnt == '0) begin
            cnt  <= half_period - 16'd1;
            tone <= ~tone;
        end else begin
            cnt  <= cnt - 16'd1;
        end
    end

endmodule

// File: rtl/sfx_sequencer.sv
// Priority-arbitrated sound-effect player driving the buzzer pin.
// Optional SFX_MUTE_EN adds a mute input that silences the buzzer without altering timing.
module sfx_sequencer
    import sfx_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       ev_fire,
    input  logic       ev_alien_died,
    input  logic       ev_dimond,
    input  logic       ev_gold,
    input  logic       ev_win,
    input  logic       ev_player_died,
`ifdef SFX_MUTE_EN
    input  logic       mute,
`endif
    output logic       buzzer,
    output logic       busy,
    output logic [2:0] fx_id
);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, NEXT} state_e;

    state_e            state;
    logic [STEP_W-1:0] step;
    logic [3:0]        frames_left;
    logic              sof_d;

    logic              frame_tick;
    logic [5:0]        ev;
    logic [2:0]        pick;
    logic              accept;
    note_t             cur_note;
    logic              next_end;
    logic              tone_load;
    logic              tone_rest;

    assign frame_tick = startOfFrame & ~sof_d;
    assign ev = {ev_player_died, ev_win, ev_gold, ev_dimond, ev_alien_died, ev_fire};

    // Highest asserted event wins; it may preempt only an equal or lower priority effect.
    always_comb begin
        pick = 3'(FX_NONE);
        for (int i = 0; i < 6; i++) begin
            if (ev[i]) pick = 3'(i);
        end
        accept = (pick != 3'(FX_NONE)) && (!busy || (pick >= fx_id));
    end

    always_comb begin
        cur_note  = script_entry(fx_id, (state == LOAD) ? '0 : step);
        next_end  = (step == STEP_W'(STEPS_PER_FX)) || (cur_note.frames == 4'd0);
        tone_load = (state == LOAD) || ((state == NEXT) && !next_end);
        tone_rest = accept || (state != PLAY) || (cur_note.note_idx == 4'd0);
`ifdef SFX_MUTE_EN
        tone_rest = tone_rest | mute;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            step        <= '0;
            frames_left <= '0;
            sof_d       <= 1'b0;
            busy        <= 1'b0;
            fx_id       <= 3'(FX_NONE);
        end else begin
            sof_d <= startOfFrame;
            if (accept) begin
                state <= LOAD;
                fx_id <= pick;
                busy  <= 1'b1;
            end else begin
                case (state)
                    IDLE: ;
                    LOAD: begin
                        step        <= '0;
                        frames_left <= cur_note.frames;
                        state       <= PLAY;
                    end
                    PLAY: begin
                        if (frame_tick) begin
                            if (frames_left <= 4'd1) begin
                                step  <= step + 3'd1;
                                state <= NEXT;
                            end else begin
                                frames_left <= frames_left - 4'd1;
                            end
                        end
                    end
                    NEXT: begin
                        if (next_end) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            fx_id <= 3'(FX_NONE);
                        end else begin
                            frames_left <= cur_note.frames;
                            state       <= PLAY;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    sfx_tone_gen u_tone (
        .clk         (clk),
        .reset       (reset),
        .load        (tone_load),
        .half_period (half_period_of(cur_note.note_idx)),
        .rest        (tone_rest),
        .tone        (buzzer)
    );

endmodule
